// File: rtl/muldiv_issue_if.sv
// muldiv_issue_if: request, multiply/divide unit and writeback signals of muldiv_issue (rev 1.0)
`default_nettype none

interface muldiv_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;

   logic        mul_enabled;
   logic [2:0]  mul_funct3;
   logic [31:0] mul_s1;
   logic [31:0] mul_s2;
   logic [31:0] mul_result;
   logic        mul_wait;

   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;

   modport master (
      input  req_valid, req_funct3, req_rs1, req_rs2, req_rd,
      output req_ready,
      output mul_enabled, mul_funct3, mul_s1, mul_s2,
      input  mul_result, mul_wait,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );

   modport slave (
      output req_valid, req_funct3, req_rs1, req_rs2, req_rd,
      input  req_ready,
      input  mul_enabled, mul_funct3, mul_s1, mul_s2,
      output mul_result, mul_wait,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_issue.sv
// muldiv_issue: issues M-extension ops to the iterative unit, resolves corner cases locally (rev 1.0)
`default_nettype none

module muldiv_issue #(
   parameter int WATCHDOG_CYCLES = 40,
   parameter int CNT_W           = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   muldiv_issue_if.master bus,
   output logic          busy,
   output logic          err_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WATCHDOG_CYCLES);

   state_t      state, state_nxt;
   logic        first_run;
   logic [2:0]  funct3_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic [4:0]  rd_q;
   logic [31:0] data_q;
   logic [CNT_W-1:0] wdog;
   logic        err_q;

   logic        ready;
   logic        accept;
   logic        bypass;
   logic [31:0] bypass_data;
   logic        in_unit;
   logic        complete;
   logic [CNT_W-1:0] wdog_nxt;

   // Corner-case results, checked in priority order from the raw request.
   always_comb begin
      logic rs1_zero, rs2_zero, ovf;
      rs1_zero    = (bus.req_rs1 == 32'd0);
      rs2_zero    = (bus.req_rs2 == 32'd0);
      ovf         = (bus.req_rs1 == 32'h8000_0000) && (bus.req_rs2 == 32'hFFFF_FFFF);
      bypass      = 1'b1;
      bypass_data = 32'd0;
      if (bus.req_funct3[2:1] == 2'b10 && rs2_zero) begin
         bypass_data = 32'hFFFF_FFFF;
      end else if (bus.req_funct3[2:1] == 2'b11 && rs2_zero) begin
         bypass_data = bus.req_rs1;
      end else if (bus.req_funct3 == 3'b100 && ovf) begin
         bypass_data = 32'h8000_0000;
      end else if (bus.req_funct3 == 3'b110 && ovf) begin
         bypass_data = 32'd0;
      end else if (rs1_zero || (!bus.req_funct3[2] && rs2_zero)) begin
         bypass_data = 32'd0;
      end else begin
         bypass = 1'b0;
      end
   end

   assign ready    = (state == IDLE) && !flush;
   assign accept   = bus.req_valid && ready;
   assign in_unit  = (state == RUN) || (state == DRAIN);
   // The unit only samples in its first enabled cycle, so mul_wait is meaningless there.
   assign complete = in_unit && !first_run && !bus.mul_wait;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = bypass ? DONE : RUN;
         end
         RUN: begin
            if (complete)   state_nxt = flush ? IDLE : DONE;
            else if (flush) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (complete) state_nxt = IDLE;
         end
         DONE: begin
            if (flush || bus.wb_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wdog_nxt = wdog;
      if (!in_unit)
         wdog_nxt = '0;
      else if (bus.mul_wait && wdog != WDOG_LIMIT)
         wdog_nxt = wdog + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         first_run <= 1'b0;
         funct3_q  <= 3'd0;
         rs1_q     <= 32'd0;
         rs2_q     <= 32'd0;
         rd_q      <= 5'd0;
         data_q    <= 32'd0;
         wdog      <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         first_run <= accept && !bypass;
         wdog      <= wdog_nxt;
         if (in_unit && wdog_nxt == WDOG_LIMIT)
            err_q <= 1'b1;
         if (accept) begin
            funct3_q <= bus.req_funct3;
            rs1_q    <= bus.req_rs1;
            rs2_q    <= bus.req_rs2;
            rd_q     <= bus.req_rd;
            if (bypass)
               data_q <= bypass_data;
         end else if (state == RUN && complete && !flush) begin
            data_q <= bus.mul_result;
         end
      end
   end

   assign bus.req_ready   = ready;
   assign bus.mul_enabled = in_unit;
   assign bus.mul_funct3  = funct3_q;
   assign bus.mul_s1      = rs1_q;
   assign bus.mul_s2      = rs2_q;
   assign bus.wb_valid    = (state == DONE);
   assign bus.wb_rd       = rd_q;
   assign bus.wb_data     = data_q;
   assign busy            = (state != IDLE);
   assign err_timeout     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_issue.sv
// tb_muldiv_issue: directed vectors and corner sequences for muldiv_issue with a behavioural unit (rev 1.0)
`default_nettype none

module tb_muldiv_issue;
   localparam int LAT = 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic busy;
   logic err_timeout;

   muldiv_issue_if bus ();

   muldiv_issue #(.WATCHDOG_CYCLES(40), .CNT_W(6)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .bus         (bus.master),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Behavioural iterative unit: samples on the first enabled cycle, then waits LAT cycles.
   logic        m_active;
   logic [3:0]  m_cnt;
   logic [31:0] m_res;
   logic [31:0] m_s1, m_s2;
   logic [2:0]  m_f;
   logic        stuck = 1'b0;
   int          hold_viol = 0;

   function automatic logic [31:0] calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] pa, pb, prod;
      pa = {{32{a[31]}}, a};
      pb = (f == 3'd2) ? {32'd0, b} : {{32{b[31]}}, b};
      prod = pa * pb;
      case (f)
         3'd0:    calc = a * b;
         3'd1:    calc = prod[63:32];
         3'd2:    calc = prod[63:32];
         3'd3:    calc = 32'(({32'd0, a} * {32'd0, b}) >> 32);
         3'd4:    calc = $signed(a) / $signed(b);
         3'd5:    calc = a / b;
         3'd6:    calc = $signed(a) % $signed(b);
         default: calc = a % b;
      endcase
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_active <= 1'b0;
         m_cnt    <= 4'd0;
         m_res    <= 32'd0;
         m_s1     <= 32'd0;
         m_s2     <= 32'd0;
         m_f      <= 3'd0;
      end else if (!bus.mul_enabled) begin
         m_active <= 1'b0;
      end else if (!m_active) begin
         m_active <= 1'b1;
         m_cnt    <= 4'(LAT);
         m_s1     <= bus.mul_s1;
         m_s2     <= bus.mul_s2;
         m_f      <= bus.mul_funct3;
         m_res    <= calc(bus.mul_funct3, bus.mul_s1, bus.mul_s2);
      end else begin
         if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
         if (bus.mul_s1 != m_s1 || bus.mul_s2 != m_s2 || bus.mul_funct3 != m_f)
            hold_viol <= hold_viol + 1;
      end
   end

   assign bus.mul_wait   = bus.mul_enabled && (stuck || !m_active || m_cnt != 4'd0);
   assign bus.mul_result = m_res;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents a request for one cycle; returns in the cycle after the accept edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      tick();
      chk1("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f;
      bus.req_rs1    = a;
      bus.req_rs2    = b;
      bus.req_rd     = rd;
      tick();
      bus.req_valid  = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      logic        byp;
      int          hold;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int   cyc;
      logic unit_seen;
      issue(v.f, v.a, v.b, v.rd);
      cyc = 0;
      unit_seen = 1'b0;
      while (!bus.wb_valid && cyc < 200) begin
         if (bus.mul_enabled) unit_seen = 1'b1;
         tick();
         cyc++;
      end
      chk1("wb_valid_seen", bus.wb_valid, 1'b1);
      if (v.byp) chk32("bypass_latency", 32'(cyc), 32'd0);
      chk1("unit_used", unit_seen, !v.byp);
      chk32("wb_data", bus.wb_data, v.exp);
      chk32("wb_rd", 32'(bus.wb_rd), 32'(v.rd));
      chk1("mul_enabled_done", bus.mul_enabled, 1'b0);
      for (int i = 0; i < v.hold; i++) begin
         tick();
         chk1("hold_wb_valid", bus.wb_valid, 1'b1);
         chk32("hold_wb_data", bus.wb_data, v.exp);
         chk1("hold_req_ready", bus.req_ready, 1'b0);
      end
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
      chk1("wb_valid_after_hs", bus.wb_valid, 1'b0);
      chk1("req_ready_after_hs", bus.req_ready, 1'b1);
   endtask

   vec_t vecs[15];

   initial begin
      int en_cyc;
      int k;
      logic wbv_seen;

      vecs[0]  = '{3'd0, 32'd7,          32'd6,          5'd3,  32'd42,          1'b0, 0};
      vecs[1]  = '{3'd5, 32'd100,        32'd0,          5'd4,  32'hFFFF_FFFF,   1'b1, 0};
      vecs[2]  = '{3'd6, 32'd100,        32'd0,          5'd5,  32'd100,         1'b1, 0};
      vecs[3]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,   1'b1, 0};
      vecs[4]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'd0,           1'b1, 0};
      vecs[5]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2,           1'b0, 5};
      vecs[6]  = '{3'd1, 32'd0,          32'd55,         5'd10, 32'd0,           1'b1, 0};
      vecs[7]  = '{3'd0, 32'd55,         32'd0,          5'd11, 32'd0,           1'b1, 0};
      vecs[8]  = '{3'd5, 32'd0,          32'd5,          5'd12, 32'd0,           1'b1, 0};
      vecs[9]  = '{3'd4, 32'd0,          32'd0,          5'd13, 32'hFFFF_FFFF,   1'b1, 0};
      vecs[10] = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd14, 32'hFFFF_FFFF,   1'b0, 0};
      vecs[11] = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd15, 32'hFFFF_FFFD,   1'b0, 0};
      vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd16, 32'hFFFF_FFFF,   1'b0, 0};
      vecs[13] = '{3'd1, 32'h4000_0000,  32'd4,          5'd17, 32'd1,           1'b0, 0};
      vecs[14] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd18, 32'd1,           1'b0, 0};

      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_rs1    = 32'd0;
      bus.req_rs2    = 32'd0;
      bus.req_rd     = 5'd0;
      bus.wb_ready   = 1'b0;

      #12;
      chk1("rst_req_ready", bus.req_ready, 1'b1);
      chk1("rst_mul_enabled", bus.mul_enabled, 1'b0);
      chk1("rst_wb_valid", bus.wb_valid, 1'b0);
      chk32("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk32("rst_wb_data", bus.wb_data, 32'd0);
      chk1("rst_err_timeout", err_timeout, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_mul_s1", bus.mul_s1, 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // div flushed on its third RUN cycle must drain until the unit finishes.
      issue(3'd4, 32'd1000, 32'd3, 5'd9);
      en_cyc = 0;
      k = 0;
      wbv_seen = 1'b0;
      while (bus.mul_enabled && k < 200) begin
         en_cyc++;
         if (bus.wb_valid) wbv_seen = 1'b1;
         flush = (en_cyc == 3);
         tick();
         k++;
      end
      flush = 1'b0;
      chk32("drain_enabled_cycles", 32'(en_cyc), 32'(LAT + 2));
      chk1("drain_no_wb_valid", wbv_seen, 1'b0);
      chk1("drain_idle_busy", busy, 1'b0);
      chk1("drain_idle_ready", bus.req_ready, 1'b1);
      tick();
      chk1("drain_wb_valid_later", bus.wb_valid, 1'b0);
      chk32("operand_hold", 32'(hold_viol), 32'd0);

      run_vec('{3'd3, 32'hFFFF_FFFF, 32'd2, 5'd19, 32'd1, 1'b0, 0});

      // Flush with a request in IDLE blocks the accept.
      tick();
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'd5;
      bus.req_rs1    = 32'd9;
      bus.req_rs2    = 32'd0;
      flush = 1'b1;
      #1;
      chk1("flush_gates_ready", bus.req_ready, 1'b0);
      tick();
      bus.req_valid = 1'b0;
      flush = 1'b0;
      chk1("flush_no_accept", busy, 1'b0);

      // Flush in DONE drops wb_valid.
      issue(3'd5, 32'd9, 32'd0, 5'd20);
      chk1("done_wb_valid", bus.wb_valid, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk1("done_flush_wb_valid", bus.wb_valid, 1'b0);
      chk1("done_flush_busy", busy, 1'b0);

      // Watchdog: unit never finishes.
      stuck = 1'b1;
      issue(3'd0, 32'd3, 32'd5, 5'd21);
      for (int i = 0; i < 39; i++) tick();
      chk1("wdog_39", err_timeout, 1'b0);
      tick();
      chk1("wdog_40", err_timeout, 1'b1);
      tick();
      chk1("wdog_still_busy", busy, 1'b1);
      chk1("wdog_still_enabled", bus.mul_enabled, 1'b1);

      // Asynchronous reset in the middle of RUN.
      reset = 1'b1;
      #1;
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_mul_enabled", bus.mul_enabled, 1'b0);
      chk1("mid_rst_err", err_timeout, 1'b0);
      chk1("mid_rst_req_ready", bus.req_ready, 1'b1);
      chk1("mid_rst_wb_valid", bus.wb_valid, 1'b0);
      chk32("mid_rst_wb_data", bus.wb_data, 32'd0);
      chk32("mid_rst_mul_s1", bus.mul_s1, 32'd0);
      stuck = 1'b0;
      tick();
      reset = 1'b0;

      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
